// File: rtl/fu_sequencer.sv
// Multi-cycle controller for the 16-bit function unit: owns the register file
// and status register, steps FS/operands through the unit and writes back.
module fu_sequencer #(
  parameter int FU_LAT = 1,
  parameter int NREG   = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic        DONE,
  input  logic        LD_EN,
  input  logic [2:0]  LD_ADDR,
  input  logic [15:0] LD_DATA,
  input  logic [2:0]  RD_ADDR,
  output logic [15:0] RD_DATA,
  output logic [3:0]  FS,
  output logic [15:0] A_BUS,
  output logic [15:0] B_BUS,
  input  logic [15:0] D_BUS,
  input  logic        FU_V,
  input  logic        FU_C,
  input  logic        FU_N,
  input  logic        FU_Z,
  output logic [3:0]  STATUS
);

  localparam logic [2:0] LAT_LAST = 3'(FU_LAT - 1);
  localparam logic [3:0] FS_NOP   = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic [15:0] regs [NREG];
  logic [3:0]  fs_q;
  logic [2:0]  dr_q;
  logic [15:0] tmp_a, tmp_b, res;
  logic [3:0]  flg, status;
  logic [2:0]  iter, lat_cnt;
  logic        armed;
  logic        accept, lat_done, is_shift;

  assign accept   = armed && INSTR_VALID;
  assign lat_done = (lat_cnt == LAT_LAST);
  assign is_shift = (INSTR[15:12] == 4'b1101) || (INSTR[15:12] == 4'b1110);
  assign RD_DATA  = regs[RD_ADDR];
  assign STATUS   = status;

  always_comb begin
    state_nxt   = state;
    INSTR_READY = 1'b0;
    DONE        = 1'b0;
    FS          = FS_NOP;
    A_BUS       = 16'h0000;
    B_BUS       = 16'h0000;
    case (state)
      IDLE: begin
        INSTR_READY = armed;
        if (accept) state_nxt = (INSTR[15:12] == FS_NOP) ? WB : EXEC;
      end
      EXEC: begin
        FS    = fs_q;
        A_BUS = tmp_a;
        B_BUS = tmp_b;
        if (lat_done) state_nxt = WB;
      end
      WB: begin
        if (iter != 3'd0) begin
          state_nxt = EXEC;
        end else begin
          DONE      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // armed keeps INSTR_READY low until the first clock after reset release
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Operands are captured at accept so a same-edge load never leaks into the op
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 16'h0000;
      fs_q    <= FS_NOP;
      dr_q    <= 3'd0;
      tmp_a   <= 16'h0000;
      tmp_b   <= 16'h0000;
      res     <= 16'h0000;
      flg     <= 4'h0;
      status  <= 4'h0;
      iter    <= 3'd0;
      lat_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (LD_EN) regs[LD_ADDR] <= LD_DATA;
          if (accept) begin
            fs_q    <= INSTR[15:12];
            dr_q    <= INSTR[11:9];
            tmp_a   <= regs[INSTR[8:6]];
            tmp_b   <= regs[INSTR[5:3]];
            iter    <= is_shift ? INSTR[2:0] : 3'd0;
            lat_cnt <= 3'd0;
          end
        end
        EXEC: begin
          if (lat_done) begin
            res <= D_BUS;
            flg <= {FU_V, FU_C, FU_N, FU_Z};
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        WB: begin
          if (iter != 3'd0) begin
            iter    <= iter - 3'd1;
            tmp_b   <= res;
            lat_cnt <= 3'd0;
          end else if (fs_q != FS_NOP) begin
            regs[dr_q] <= res;
            status     <= fs_q[3] ? {2'b00, flg[1:0]} : flg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer with a behavioural function unit attached.
module tb_fu_sequencer;

  localparam int LAT    = 2;
  localparam int BUDGET = 16 * (LAT + 1);

  logic        clk, rstN;
  logic [15:0] instr;
  logic        instrValid, instrReady, done;
  logic        ldEn;
  logic [2:0]  ldAddr, rdAddr;
  logic [15:0] ldData, rdData;
  logic [3:0]  fs, status;
  logic [15:0] aBus, bBus, dBus;
  logic        fuV, fuC, fuN, fuZ;

  int errCount   = 0;
  int checkCount = 0;

  fu_sequencer #(.FU_LAT(LAT), .NREG(8)) dut (
    .CLK(clk), .RESET_N(rstN),
    .INSTR(instr), .INSTR_VALID(instrValid), .INSTR_READY(instrReady), .DONE(done),
    .LD_EN(ldEn), .LD_ADDR(ldAddr), .LD_DATA(ldData),
    .RD_ADDR(rdAddr), .RD_DATA(rdData),
    .FS(fs), .A_BUS(aBus), .B_BUS(bBus), .D_BUS(dBus),
    .FU_V(fuV), .FU_C(fuC), .FU_N(fuN), .FU_Z(fuZ),
    .STATUS(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-bit function unit driven by the sequencer
  logic [15:0] op2, logicRes;
  logic [16:0] sum;
  logic        cin, isArith;
  always_comb begin
    op2 = 16'h0000; cin = 1'b0; isArith = 1'b1; logicRes = 16'h0000;
    case (fs)
      4'b0000: ;
      4'b0001: cin = 1'b1;
      4'b0010: op2 = bBus;
      4'b0011: begin op2 = bBus; cin = 1'b1; end
      4'b0100: op2 = ~bBus;
      4'b0101: begin op2 = ~bBus; cin = 1'b1; end
      4'b0110: op2 = 16'hFFFF;
      4'b0111: ;
      default: isArith = 1'b0;
    endcase
    case (fs)
      4'b1000: logicRes = aBus & bBus;
      4'b1001: logicRes = aBus | bBus;
      4'b1010: logicRes = aBus ^ bBus;
      4'b1011: logicRes = ~aBus;
      4'b1100: logicRes = bBus;
      4'b1101: logicRes = bBus >> 1;
      4'b1110: logicRes = bBus << 1;
      default: logicRes = 16'h0000;
    endcase
    sum  = {1'b0, aBus} + {1'b0, op2} + {16'h0000, cin};
    dBus = isArith ? sum[15:0] : logicRes;
    fuC  = isArith & sum[16];
    fuV  = isArith & (aBus[15] == op2[15]) & (sum[15] != aBus[15]);
    fuN  = dBus[15];
    fuZ  = (dBus == 16'h0000);
  end

  function automatic logic [15:0] mkInstr(input logic [3:0] f, input logic [2:0] dr,
                                          input logic [2:0] sa, input logic [2:0] sb,
                                          input logic [2:0] cnt);
    return {f, dr, sa, sb, cnt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rdAddr = a;
    #1;
    checkOutput(tag, {16'h0, rdData}, {16'h0, exp});
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ldEn = 1'b1; ldAddr = a; ldData = d;
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  // ldMode: 0 none, 1 load on the accept edge, 2 load attempt during EXEC
  task automatic applyStimulus(input logic [15:0] ins, input int ldMode,
                               input logic [2:0] ldA, input logic [15:0] ldD,
                               output int doneCycle, output int doneCnt,
                               output logic readyC1);
    @(negedge clk);
    instr = ins; instrValid = 1'b1;
    if (ldMode == 1) begin ldEn = 1'b1; ldAddr = ldA; ldData = ldD; end
    doneCycle = 0; doneCnt = 0; readyC1 = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (doneCycle == 0) doneCycle = c;
      end
      if (c == 1) begin readyC1 = instrReady; instrValid = 1'b0; ldEn = 1'b0; end
      if (ldMode == 2 && c == 2) begin ldEn = 1'b1; ldAddr = ldA; ldData = ldD; end
      if (ldMode == 2 && c == 3) ldEn = 1'b0;
    end
  endtask

  int   dc, dn, dc2;
  logic r1, r4;

  initial begin
    rstN = 1'b0; instr = 16'h0; instrValid = 1'b0;
    ldEn = 1'b0; ldAddr = 3'd0; ldData = 16'h0; rdAddr = 3'd0;

    #3;
    checkOutput("rst_ready", instrReady, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_fs", fs, 4'hF);
    checkOutput("rst_abus", aBus, 16'h0);
    checkOutput("rst_bbus", bBus, 16'h0);
    checkOutput("rst_status", status, 4'h0);
    checkReg("rst_r5", 3'd5, 16'h0);
    @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", instrReady, 1'b1);

    // 0x7FFF + 0x0001 with signed overflow
    loadReg(3'd1, 16'h7FFF);
    loadReg(3'd2, 16'h0001);
    applyStimulus(mkInstr(4'b0010, 3'd3, 3'd1, 3'd2, 3'd0), 0, 3'd0, 16'h0, dc, dn, r1);
    checkOutput("add_latency", dc, LAT + 1);
    checkOutput("add_done_count", dn, 1);
    checkOutput("add_ready_busy", r1, 1'b0);
    checkReg("add_r3", 3'd3, 16'h8000);
    checkOutput("add_status", status, 4'b1010);

    // 5 - 5 followed by a NOP held pending while the subtract runs
    loadReg(3'd4, 16'h0005);
    @(negedge clk);
    instr = mkInstr(4'b0101, 3'd5, 3'd4, 3'd4, 3'd0); instrValid = 1'b1;
    dc = 0; dc2 = 0; dn = 0; r1 = 1'b1; r4 = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dc == 0) dc = c; else if (dc2 == 0) dc2 = c;
      end
      if (c == 1) begin r1 = instrReady; instr = mkInstr(4'b1111, 3'd2, 3'd0, 3'd0, 3'd0); end
      if (c == LAT + 2) r4 = instrReady;
      if (c == LAT + 3) instrValid = 1'b0;
    end
    checkOutput("sub_latency", dc, LAT + 1);
    checkOutput("nop_latency", dc2, LAT + 3);
    checkOutput("sub_nop_done_count", dn, 2);
    checkOutput("sub_ready_busy", r1, 1'b0);
    checkOutput("ready_after_done", r4, 1'b1);
    checkReg("sub_r5", 3'd5, 16'h0000);
    checkReg("nop_r2", 3'd2, 16'h0001);
    checkOutput("nop_status", status, 4'b0101);

    // Shift left 4 times; a load attempt during EXEC must be ignored
    loadReg(3'd6, 16'h0001);
    applyStimulus(mkInstr(4'b1110, 3'd7, 3'd0, 3'd6, 3'd3), 2, 3'd0, 16'hABCD, dc, dn, r1);
    checkOutput("shl_latency", dc, 4 * (LAT + 1));
    checkOutput("shl_done_count", dn, 1);
    checkReg("shl_r7", 3'd7, 16'h0010);
    checkOutput("shl_status", status, 4'b0000);
    checkReg("busy_load_r0", 3'd0, 16'h0000);

    // Same-edge load of R1 and transfer of R1 into R2
    applyStimulus(mkInstr(4'b0000, 3'd2, 3'd1, 3'd0, 3'd0), 1, 3'd1, 16'h00FF, dc, dn, r1);
    checkOutput("xfer_latency", dc, LAT + 1);
    checkReg("xfer_r2_old", 3'd2, 16'h7FFF);
    checkReg("xfer_r1_new", 3'd1, 16'h00FF);
    checkOutput("xfer_status", status, 4'b0000);

    // Reset asserted mid-EXEC
    @(negedge clk);
    instr = mkInstr(4'b0010, 3'd3, 3'd1, 3'd2, 3'd0); instrValid = 1'b1;
    @(negedge clk);
    instrValid = 1'b0;
    checkOutput("midrst_in_exec", fs, 4'b0010);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_ready", instrReady, 1'b0);
    checkOutput("midrst_status", status, 4'h0);
    checkOutput("midrst_fs", fs, 4'hF);
    checkReg("midrst_r1", 3'd1, 16'h0);
    checkReg("midrst_r7", 3'd7, 16'h0);
    @(negedge clk);
    #2 rstN = 1'b1;
    dn = 0;
    @(negedge clk);
    checkOutput("midrst_ready_after", instrReady, 1'b1);
    for (int c = 0; c < 2 * (LAT + 1); c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checkOutput("midrst_no_done", dn, 0);
    checkReg("midrst_r3", 3'd3, 16'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
Multi-cycle controller that sequences the 16-bit function unit (FS/A/B -> D, V/C/N/Z). Owns an 8x16 register file and status register, accepts one encoded micro-instruction per valid/ready handshake, drives FS and operands to the function unit, samples the result and flags, and writes back. Shift instructions are iterated CNT+1 times through the unit to give multi-bit shifts.

Parameters:
FU_LAT, 1, cycles operands/FS are held stable before D and flags are sampled (1..4)
NREG, 8, register file depth (fixed at 8; 3-bit addresses)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
INSTR  in  16  [15:12] FS, [11:9] DR, [8:6] SA, [5:3] SB, [2:0] CNT
INSTR_VALID  in  1  INSTR present
INSTR_READY  out  1  sequencer idle, will accept INSTR
DONE  out  1  one-cycle pulse in write-back cycle of the final iteration
LD_EN  in  1  direct register load (honoured only in IDLE)
LD_ADDR  in  3  load address
LD_DATA  in  16  load data
RD_ADDR  in  3  debug read address
RD_DATA  out  16  combinational read of register RD_ADDR
FS  out  4  function select to function unit
A_BUS  out  16  A operand
B_BUS  out  16  B operand
D_BUS  in  16  function unit result
FU_V, FU_C, FU_N, FU_Z  in  1 each  function unit flags
STATUS  out  4  {V,C,N,Z} of last completed instruction

Behaviour:
- Reset (async, RESET_N low): state IDLE, all registers 0, STATUS 0, FS 4'b1111, A_BUS/B_BUS 0, DONE 0, INSTR_READY 0 while RESET_N low, 1 from first clock in IDLE.
- States: IDLE, EXEC, WB.
- IDLE: INSTR_READY=1. INSTR_VALID=1 at edge -> latch INSTR, load TMP_B <= R[SB], iter <= CNT if FS is 1101/1110 else 0, go EXEC. LD_EN=1 in IDLE writes R[LD_ADDR]; if INSTR_VALID and LD_EN same edge, load occurs and instruction reads pre-load values.
- FS=1111 (hold) is a NOP: accepted, goes directly to WB with no register write, DONE pulses, STATUS unchanged.
- EXEC: FS=latched FS, A_BUS=R[SA], B_BUS=TMP_B, held stable FU_LAT cycles (counter). At end of last EXEC cycle sample D_BUS into RES and flags into FLG; go WB.
- WB: if iter>0: iter--, TMP_B <= RES, go EXEC (no write, no DONE). Else R[DR] <= RES, DONE=1, STATUS updated, go IDLE.
- STATUS update: FS 0000-0111 -> {FU_V,FU_C,FU_N,FU_Z}; FS 1000-1110 -> {0,0,FU_N,FU_Z} taken from final iteration.
- Latency: non-shift instruction accepted at edge 0 -> DONE high in cycle FU_LAT+1; shift with CNT=k -> (k+1)*(FU_LAT+1).
- INSTR_READY low in EXEC/WB; INSTR_VALID ignored there; next accept earliest one cycle after DONE.
- DR==SA or DR==SB: operands read before write-back; write-back visible to following instruction.
- RD_DATA reflects write in cycle after WB edge.
- Reset mid-operation: aborts immediately, no write-back, no DONE.
- LD_EN outside IDLE ignored.

Test Plan:
- Reset with R1..R2 loaded, RESET_N low mid-EXEC -> all regs 0, STATUS 0, no DONE, INSTR_READY 1 after release.
- LD R1=0x7FFF, R2=0x0001; INSTR FS=0010 DR=3 SA=1 SB=2 -> R3=0x8000, STATUS V=1,C=0,N=1,Z=0, DONE at cycle FU_LAT+1.
- LD R4=0x0005; FS=0101 DR=5 SA=4 SB=4 -> R5=0x0000, Z=1, C=1.
- LD R6=0x0001; FS=1110 DR=7 SB=6 CNT=3 -> R7=0x0010, DONE at cycle 4*(FU_LAT+1), exactly one DONE pulse.
- FS=1111 DR=2 -> R2 unchanged, STATUS unchanged, DONE pulses; INSTR_VALID held high during EXEC of prior op -> second op accepted only after DONE.
- Same-edge LD_EN (R1<-0x00FF) and FS=0000 DR=2 SA=1 -> R2 gets old R1, R1=0x00FF afterwards.
